// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: registered control decoder with two-word, halt and interrupt-entry sequencing.
module ctrl_sequencer #(
  parameter int OPCODE_W   = 7,
  parameter int ALU_OP_W   = 4,
  parameter int INT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic                intr,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_we,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                imm_sel,
  output logic                port_in,
  output logic                port_out,
  output logic                set_c,
  output logic                ctrl_valid,
  output logic                fetch_imm,
  output logic                halted,
  output logic                int_ack,
  output logic                vec_load,
  output logic                illegal
);
  typedef enum logic [1:0] {RUN, IMM, HALT, INT} state_t;
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu;
    logic we, rd, wr, imm, pin, pout, setc, cv;
  } fld_t;

  function automatic fld_t f(input int a, input logic [7:0] b);
    return {ALU_OP_W'(a), b};
  endfunction

  localparam fld_t BUBBLE = {ALU_OP_W'(15), 8'h00};
  localparam fld_t PUSH   = {ALU_OP_W'(5), 8'b0010_0001};

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       pend, pend_n;
  fld_t       lat, lat_n, out, out_n, dec;
  logic       fi_n, ha_n, ack_n, vec_n, ill_n;
  logic       two, hlt, legal, take;

  // flag byte order: we rd wr imm pin pout setc cv
  always_comb begin
    dec = BUBBLE;
    two = 1'b0;
    hlt = 1'b0;
    legal = 1'b1;
    case (opcode[6:0])
      7'b0010001: dec = f(4, 8'b1000_0001);
      7'b0000011: dec = f(1, 8'b1000_0001);
      7'b0011001: dec = f(5, 8'b0000_0101);
      7'b0011000: dec = f(5, 8'b1000_1001);
      7'b1100001: begin dec = f(15, 8'b0000_0001); hlt = 1'b1; end
      7'b1101000: dec = f(15, 8'b0000_0001);
      7'b1100010: dec = f(0, 8'b0000_0011);
      7'b0010101: dec = f(5, 8'b1000_0001);
      7'b0000001: dec = f(0, 8'b1000_0001);
      7'b0001001: dec = f(2, 8'b1000_0001);
      7'b0001101: dec = f(3, 8'b1000_0001);
      7'b0100000: begin dec = f(0, 8'b1001_0001); two = 1'b1; end
      7'b0110101: begin dec = f(5, 8'b1001_0001); two = 1'b1; end
      7'b0100010: begin dec = f(0, 8'b1101_0001); two = 1'b1; end
      7'b0100011: begin dec = f(0, 8'b0011_0001); two = 1'b1; end
      default: legal = 1'b0;
    endcase
    if ((opcode >> 7) != '0) legal = 1'b0;
    if (!legal) begin
      dec = BUBBLE;
      two = 1'b0;
      hlt = 1'b0;
    end
  end

  assign take = pend | intr;

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    lat_n = lat;
    out_n = out;
    pend_n = pend;
    fi_n = fetch_imm;
    ha_n = halted;
    ack_n = 1'b0;
    vec_n = 1'b0;
    ill_n = 1'b0;
    if (flush) begin
      out_n = BUBBLE;
      fi_n = 1'b0;
      pend_n = take | (state == INT);
      state_n = (state == HALT) ? HALT : RUN;
    end else if (!stall) begin
      out_n = BUBBLE;
      fi_n = 1'b0;
      pend_n = (state == INT) ? pend : take;
      if ((state == RUN || state == HALT) && take) begin
        state_n = INT;
        out_n = PUSH;
        ack_n = 1'b1;
        cnt_n = 4'd1;
        pend_n = 1'b0;
        ha_n = 1'b0;
      end else if (state == RUN && instr_valid) begin
        out_n = two ? BUBBLE : dec;
        ill_n = !legal;
        fi_n = two;
        lat_n = two ? dec : lat;
        state_n = two ? IMM : (hlt ? HALT : RUN);
        ha_n = hlt;
      end else if (state == IMM) begin
        out_n = instr_valid ? lat : BUBBLE;
        fi_n = !instr_valid;
        state_n = instr_valid ? RUN : IMM;
      end else if (state == INT) begin
        out_n = (cnt < 4'(INT_CYCLES)) ? PUSH : BUBBLE;
        vec_n = !(cnt < 4'(INT_CYCLES));
        state_n = (cnt < 4'(INT_CYCLES)) ? INT : RUN;
        cnt_n = cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      lat <= BUBBLE;
      out <= BUBBLE;
      pend <= 1'b0;
      fetch_imm <= 1'b0;
      halted <= 1'b0;
      int_ack <= 1'b0;
      vec_load <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lat <= lat_n;
      out <= out_n;
      pend <= pend_n;
      fetch_imm <= fi_n;
      halted <= ha_n;
      int_ack <= ack_n;
      vec_load <= vec_n;
      illegal <= ill_n;
    end
  end

  assign {alu_op, reg_we, mem_rd, mem_wr, imm_sel, port_in, port_out, set_c, ctrl_valid} = out;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: vector table plus hand sequences, checked through an expected-value queue.
module tb_ctrl_sequencer;
  logic clk = 0, reset = 1, instr_valid = 0, stall = 0, flush = 0, intr = 0;
  logic [6:0] opcode = '0;
  logic [3:0] alu_op;
  logic reg_we, mem_rd, mem_wr, imm_sel, port_in, port_out, set_c, ctrl_valid;
  logic fetch_imm, halted, int_ack, vec_load, illegal;
  logic [8:0] opcode9 = '0;
  logic v9 = 0;
  logic [3:0] alu9;
  logic we9, rd9, wr9, imm9, pin9, pout9, sc9, cv9, fi9, ha9, ack9, vec9, ill9;
  logic [16:0] got, got9;
  logic [16:0] sb[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ctrl_sequencer dut (.clk(clk), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .intr(intr), .alu_op(alu_op), .reg_we(reg_we), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .imm_sel(imm_sel), .port_in(port_in), .port_out(port_out), .set_c(set_c),
    .ctrl_valid(ctrl_valid), .fetch_imm(fetch_imm), .halted(halted), .int_ack(int_ack),
    .vec_load(vec_load), .illegal(illegal));

  ctrl_sequencer #(.OPCODE_W(9)) dut9 (.clk(clk), .reset(reset), .opcode(opcode9), .instr_valid(v9),
    .stall(1'b0), .flush(1'b0), .intr(1'b0), .alu_op(alu9), .reg_we(we9), .mem_rd(rd9),
    .mem_wr(wr9), .imm_sel(imm9), .port_in(pin9), .port_out(pout9), .set_c(sc9),
    .ctrl_valid(cv9), .fetch_imm(fi9), .halted(ha9), .int_ack(ack9), .vec_load(vec9),
    .illegal(ill9));

  assign got = {alu_op, reg_we, mem_rd, mem_wr, imm_sel, port_in, port_out, set_c, ctrl_valid,
                fetch_imm, halted, int_ack, vec_load, illegal};
  assign got9 = {alu9, we9, rd9, wr9, imm9, pin9, pout9, sc9, cv9, fi9, ha9, ack9, vec9, ill9};

  typedef struct {
    logic [6:0] op;
    logic v, st, fl, in;
    logic [16:0] e;
    string nm;
  } vec_t;
  vec_t tbl[$];

  localparam logic [6:0] NOT = 7'b0010001, INC = 7'b0000011, OUT = 7'b0011001, IN = 7'b0011000,
    HLT = 7'b1100001, NOP = 7'b1101000, SETC = 7'b1100010, MOV = 7'b0010101, ADD = 7'b0000001,
    SUB = 7'b0001001, AND = 7'b0001101, IADD = 7'b0100000, LDM = 7'b0110101, LDD = 7'b0100010,
    STD = 7'b0100011;

  // expected = {alu, we rd wr imm pin pout setc cv, fetch_imm halted ack vec illegal}
  function automatic logic [16:0] E(input logic [3:0] a, input logic [7:0] fl, input logic [4:0] p);
    return {a, fl, p};
  endfunction

  localparam logic [16:0] BUB = {4'd15, 8'h00, 5'b00000};
  localparam logic [16:0] FI  = {4'd15, 8'h00, 5'b10000};
  localparam logic [16:0] HB  = {4'd15, 8'h00, 5'b01000};
  localparam logic [16:0] ACK = {4'd5, 8'b0010_0001, 5'b00100};
  localparam logic [16:0] PSH = {4'd5, 8'b0010_0001, 5'b00000};
  localparam logic [16:0] VEC = {4'd15, 8'h00, 5'b00010};
  localparam logic [16:0] R_ADD = {4'd0, 8'b1000_0001, 5'b00000};

  task automatic add(input string nm, input logic [6:0] op, input logic v, st, fl, in,
                     input logic [16:0] e);
    vec_t t;
    t.op = op; t.v = v; t.st = st; t.fl = fl; t.in = in; t.e = e; t.nm = nm;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [16:0] g, input logic [16:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, g, e);
    end
  endtask

  task automatic step(input string nm, input logic [6:0] op, input logic v, st, fl, in,
                      input logic [16:0] e);
    opcode = op; instr_valid = v; stall = st; flush = fl; intr = in;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else chk(nm, got, sb.pop_front());
  endtask

  initial begin
    add("add", ADD, 1, 0, 0, 0, R_ADD);
    add("idle", 0, 0, 0, 0, 0, BUB);
    add("ldd_w1", LDD, 1, 0, 0, 0, FI);
    add("ldd_w2", 7'h7f, 1, 0, 0, 0, E(0, 8'b1101_0001, 0));
    add("ldd_done", 0, 0, 0, 0, 0, BUB);
    add("std_w1", STD, 1, 0, 0, 0, FI);
    add("std_st1", 0, 0, 1, 0, 0, FI);
    add("std_st2", ADD, 1, 1, 0, 0, FI);
    add("std_st3", 0, 0, 1, 0, 0, FI);
    add("std_w2", 0, 1, 0, 0, 0, E(0, 8'b0011_0001, 0));
    add("std2_w1", STD, 1, 0, 0, 0, FI);
    add("std2_flush", ADD, 1, 0, 1, 0, BUB);
    add("sub", SUB, 1, 0, 0, 0, E(2, 8'b1000_0001, 0));
    add("not", NOT, 1, 0, 0, 0, E(4, 8'b1000_0001, 0));
    add("not_stall", SUB, 1, 1, 0, 0, E(4, 8'b1000_0001, 0));
    add("ill", 7'h7f, 1, 0, 0, 0, {4'd15, 8'h00, 5'b00001});
    add("ill_stall", 0, 0, 1, 0, 0, BUB);
    add("inc", INC, 1, 0, 0, 0, E(1, 8'b1000_0001, 0));
    add("out", OUT, 1, 0, 0, 0, E(5, 8'b0000_0101, 0));
    add("in", IN, 1, 0, 0, 0, E(5, 8'b1000_1001, 0));
    add("setc", SETC, 1, 0, 0, 0, E(0, 8'b0000_0011, 0));
    add("nop", NOP, 1, 0, 0, 0, E(15, 8'b0000_0001, 0));
    add("mov", MOV, 1, 0, 0, 0, E(5, 8'b1000_0001, 0));
    add("and", AND, 1, 0, 0, 0, E(3, 8'b1000_0001, 0));
    add("iadd_w1", IADD, 1, 0, 0, 0, FI);
    add("iadd_w2", 0, 1, 0, 0, 0, E(0, 8'b1001_0001, 0));
    add("ldm_w1", LDM, 1, 0, 0, 0, FI);
    add("ldm_gap", 0, 0, 0, 0, 0, FI);
    add("ldm_w2", 0, 1, 0, 0, 0, E(5, 8'b1001_0001, 0));
    add("hlt", HLT, 1, 0, 0, 0, E(15, 8'b0000_0001, 5'b01000));
    for (int i = 0; i < 10; i++) add($sformatf("halt_%0d", i), ADD, 1, 0, 0, 0, HB);
    add("halt_flush", ADD, 1, 0, 1, 0, HB);
    add("halt_intr", 0, 0, 0, 0, 1, ACK);
    add("int_push2", 0, 0, 0, 0, 0, PSH);
    add("int_vec", 0, 0, 0, 0, 0, VEC);
    add("after_int", ADD, 1, 0, 0, 0, R_ADD);
    add("run_intr", ADD, 1, 0, 0, 1, ACK);
    add("run_push2", ADD, 1, 0, 0, 0, PSH);
    add("run_vec", ADD, 1, 0, 0, 0, VEC);
    add("represent", ADD, 1, 0, 0, 0, R_ADD);
    add("imm_w1", LDD, 1, 0, 0, 0, FI);
    add("imm_intr", 0, 0, 0, 0, 1, FI);
    add("imm_w2", 0, 1, 0, 0, 0, E(0, 8'b1101_0001, 0));
    add("pend_take", 0, 0, 0, 0, 0, ACK);
    add("pend_push2", 0, 0, 0, 0, 0, PSH);
    add("pend_vec", 0, 0, 0, 0, 0, VEC);
    add("fl_intr", 0, 0, 0, 0, 1, ACK);
    add("fl_int", 0, 0, 0, 1, 0, BUB);
    add("fl_retake", 0, 0, 0, 0, 0, ACK);
    add("fl_push2", 0, 0, 0, 0, 0, PSH);
    add("fl_vec", 0, 0, 0, 0, 0, VEC);
    add("fl_idle", 0, 0, 0, 0, 0, BUB);

    repeat (2) @(posedge clk);
    #1;
    chk("reset", got, BUB);
    chk("reset9", got9, BUB);
    reset = 0;
    foreach (tbl[i]) step(tbl[i].nm, tbl[i].op, tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].in, tbl[i].e);

    step("rst_intr", 0, 0, 0, 0, 1, ACK);
    step("rst_push2", 0, 0, 0, 0, 0, PSH);
    reset = 1;
    step("rst_mid_int", 0, 0, 0, 0, 0, BUB);
    reset = 0;
    step("rst_no_vec", 0, 0, 0, 0, 0, BUB);
    step("rst_no_pend", 0, 0, 0, 0, 0, BUB);
    step("rst_run", SUB, 1, 0, 0, 0, E(2, 8'b1000_0001, 0));

    opcode9 = 9'h101; v9 = 1;
    @(posedge clk); #1;
    chk("wide_hi_ill", got9, {4'd15, 8'h00, 5'b00001});
    opcode9 = 9'h001;
    @(posedge clk); #1;
    chk("wide_add", got9, R_ADD);
    v9 = 0;
    @(posedge clk); #1;
    chk("wide_idle", got9, BUB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
